// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage access controller.
//   - RV32I load/store funct3 encodings
//   - FSM state enum
//   - wait counter width, byte-lane geometry
//   - latched-op struct carried through the REQ state
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Wait counter width; MAX_WAIT is limited to 1..255 so 8 bits always suffice.
  localparam int CNT_W     = 8;
  localparam int NUM_LANES = 4;
  localparam int BYTE_W    = 8;

  typedef enum logic {IDLE, REQ} state_t;

  // Op held for the whole REQ phase; feeds the wb_* registers on load completion.
  typedef struct packed {
    logic        is_load;
    logic [2:0]  funct3;
    logic [31:0] alu_c;
  } mem_op_t;

endpackage

// File: rtl/mem_access_ctrl_store_align.sv
// store_align: combinational legality check plus store lane steering.
//   is_load  in  1   op is a load (unsigned loads only legal as loads)
//   funct3   in  3   RV32I load/store funct3
//   k        in  2   byte offset alu_c[1:0]
//   rs2      in  32  store data
//   wstrb    out 4   byte enables (0 for loads and illegal ops)
//   wdata    out 32  store data moved to its byte lanes, unstrobed lanes 0
//   legal    out 1   size/offset/funct3 combination is allowed
module store_align
  import mem_pkg::*;
(
  input  logic        is_load,
  input  logic [2:0]  funct3,
  input  logic [1:0]  k,
  input  logic [31:0] rs2,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic        legal
);

  logic [NUM_LANES-1:0] size_mask;
  logic [31:0]          shifted;

  always_comb begin
    legal     = 1'b0;
    size_mask = '0;
    case (funct3)
      F3_LB:  begin legal = 1'b1;                size_mask = 4'b0001; end
      F3_LH:  begin legal = (k != 2'd3);         size_mask = 4'b0011; end
      F3_LW:  begin legal = (k == 2'd0);         size_mask = 4'b1111; end
      F3_LBU: begin legal = is_load;             size_mask = 4'b0001; end
      F3_LHU: begin legal = is_load && k != 2'd3; size_mask = 4'b0011; end
      default: begin legal = 1'b0;               size_mask = '0;      end
    endcase
  end

  // Legal cases never shift a set bit past lane 3, so no truncation loss.
  assign wstrb   = (is_load || !legal) ? '0 : (size_mask << k);
  assign shifted = rs2 << {k, 3'b000};

  for (genvar lane = 0; lane < NUM_LANES; lane++) begin : g_lane
    assign wdata[lane*BYTE_W +: BYTE_W] =
      wstrb[lane] ? shifted[lane*BYTE_W +: BYTE_W] : '0;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM pipeline stage. Accepts a load/store in IDLE, checks
// alignment, issues one registered RAM request and waits for dram_ready,
// aborting after MAX_WAIT+1 unanswered request cycles.
//   clk, rst_n                     clock / async active-low reset
//   ex_valid, ex_mem_read/write    op valid, load, store
//   ex_funct3, ex_alu_c, ex_rs2    size, byte address, store data
//   mem_stall                      hold upstream while a request is open
//   dram_req/we/addr/wstrb/wdata   RAM request (registered, stable in REQ)
//   dram_ready, dram_rdata         RAM accept; read word valid with ready
//   wb_valid, wb_RD, wb_funct3,    load completion pulse + raw word, funct3
//   wb_alu_c                       and byte address for the load aligner
//   misalign                       pulse: illegal/misaligned op dropped
//   bus_err                        pulse: request timed out
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_alu_c,
  input  logic [31:0] ex_rs2,
  output logic        mem_stall,
  output logic        dram_req,
  output logic        dram_we,
  output logic [29:0] dram_addr,
  output logic [3:0]  dram_wstrb,
  output logic [31:0] dram_wdata,
  input  logic        dram_ready,
  input  logic [31:0] dram_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_RD,
  output logic [2:0]  wb_funct3,
  output logic [31:0] wb_alu_c,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  mem_op_t          op;

  logic        accept;
  logic        op_ok;
  logic        sa_legal;
  logic [3:0]  sa_wstrb;
  logic [31:0] sa_wdata;

  store_align u_align (
    .is_load (ex_mem_read),
    .funct3  (ex_funct3),
    .k       (ex_alu_c[1:0]),
    .rs2     (ex_rs2),
    .wstrb   (sa_wstrb),
    .wdata   (sa_wdata),
    .legal   (sa_legal)
  );

  assign accept    = (state == IDLE) && ex_valid && (ex_mem_read || ex_mem_write);
  // Read and write together is a malformed op and is dropped like a misalign.
  assign op_ok     = sa_legal && !(ex_mem_read && ex_mem_write);
  assign mem_stall = (state == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      op         <= '0;
      dram_req   <= 1'b0;
      dram_we    <= 1'b0;
      dram_addr  <= '0;
      dram_wstrb <= '0;
      dram_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_RD      <= '0;
      wb_funct3  <= '0;
      wb_alu_c   <= '0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_ok) begin
              state      <= REQ;
              wait_cnt   <= '0;
              dram_req   <= 1'b1;
              dram_we    <= ex_mem_write;
              dram_addr  <= ex_alu_c[31:2];
              dram_wstrb <= sa_wstrb;
              dram_wdata <= sa_wdata;
              op         <= '{is_load: ex_mem_read, funct3: ex_funct3, alu_c: ex_alu_c};
            end else begin
              misalign <= 1'b1;
            end
          end
        end
        REQ: begin
          if (dram_ready) begin
            state    <= IDLE;
            dram_req <= 1'b0;
            if (op.is_load) begin
              wb_valid  <= 1'b1;
              wb_RD     <= dram_rdata;
              wb_funct3 <= op.funct3;
              wb_alu_c  <= op.alu_c;
            end
          end else if (wait_cnt == WAIT_LIM) begin
            state    <= IDLE;
            dram_req <= 1'b0;
            bus_err  <= 1'b1;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
